hd44780_read_operation: RTL and testbench
=========================================

# hd44780_read_operation

Bus-read engine for the HD44780 character LCD: the counterpart of the write-operation block. It drives RS/RW/E through a complete read cycle, releases the data bus, and samples DB7..DB0 while E is high. Each cycle returns either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM byte (RS=1). It sits beside the write engine under the LCD controller FSM. That controller polls the busy flag through this block before issuing each write.

## Interface
Parameters:
- T_AS, 1, i_ena ticks from RS/RW valid to E rising (address setup); legal range ≥1
- T_EH, 2, i_ena ticks E held high; i_db is sampled on the last of these; legal range ≥1
- T_EL, 2, i_ena ticks E held low after the pulse, before completion or the next pulse; legal range ≥1

Ports:
- i_clk  input  1  system clock; all logic on its rising edge
- i_reset_n  input  1  reset, asynchronous, active-low
- i_ena  input  1  timing tick strobe; phase counters advance only on cycles where it is 1
- i_start  input  1  read request; level-sampled every clock edge
- i_rs  input  1  register select for the request (0 = busy flag/address, 1 = data RAM)
- i_db  input  8  LCD data bus, as seen by the FPGA input buffers
- o_rs  output  1  LCD RS pin
- o_rw  output  1  LCD R/W pin (1 = read)
- o_e  output  1  LCD E pin
- o_bus_req  output  1  high while this block owns the LCD pins; top level tristates the FPGA DB drivers and muxes RS/RW/E from this block
- o_busy  output  1  operation in progress; i_start is ignored while high
- o_valid  output  1  one-clock pulse; o_data/o_bf/o_ac are valid from this cycle on
- o_data  output  8  byte read
- o_bf  output  1  busy flag, equal to o_data[7] when the read used RS=0; 0 after an RS=1 read
- o_ac  output  7  address counter, equal to o_data[6:0] when the read used RS=0; unchanged after an RS=1 read

## Operation
- States: IDLE, SETUP, E_HIGH, E_LOW, DONE.
  - The 4-bit build adds a second E_HIGH/E_LOW pass, tracked by a nibble bit.
- IDLE:
  - On any clock edge with i_start=1, latch i_rs into o_rs, then set o_rw=1, o_bus_req=1, o_busy=1.
  - Load the counter with T_AS and go to SETUP.
  - Acceptance does not wait for i_ena.
- SETUP: on each tick, decrement; at expiry set o_e=1, load T_EH, go to E_HIGH.
- E_HIGH:
  - On each tick, decrement.
  - On the expiry tick, capture i_db into the shift/data register on the same edge that clears o_e.
  - Then load T_EL and go to E_LOW.
- E_LOW: on each tick, decrement; at expiry go to DONE (or start the next nibble's E_HIGH in 4-bit mode).
- DONE (one clock, ena-independent):
  - Pulse o_valid and update o_data/o_bf/o_ac.
  - Clear o_rw, o_bus_req and o_busy; return to IDLE.
  - o_rs holds its last value.
- i_start held high re-arms only in IDLE, so back-to-back reads are separated by exactly one idle clock.
- Changes to i_rs or i_start mid-operation are ignored.

## Timing
- Reset values: o_rs=0, o_rw=0, o_e=0, o_bus_req=0, o_busy=0, o_valid=0, o_data=0, o_bf=0, o_ac=0; state IDLE.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously), and no o_valid is produced.
- RS and RW settle ≥T_AS ticks before E rises.
- RW stays high until ≥T_EL ticks after E falls.
- o_e is never high while o_rw=0.
- Latency, accept edge to o_valid:
  - 8-bit build: T_AS+T_EH+T_EL ticks plus 1 clock.
  - 4-bit build: T_AS+2·(T_EH+T_EL) ticks plus 1 clock.
- i_ena high on the accept edge does not count toward SETUP.
- Counter width is clog2 of the largest parameter plus 1.

## Configuration
- HD44780_READ_4BIT_EN defined:
  - The block performs two E pulses per read.
  - The first captures i_db[7:4] into o_data[7:4]; the second captures i_db[7:4] into o_data[3:0].
  - i_db[3:0] is ignored.
- Undefined: one E pulse, with all 8 bits captured from i_db[7:0].

## Test plan
- Busy-flag read, 8-bit, defaults, i_ena every 5 clocks:
  - Stimulus: i_rs=0, i_db=8'hA5, one-clock i_start.
  - Required: o_e high for exactly 10 clocks; o_valid 5 ticks + 1 clock after accept; o_data=A5, o_bf=1, o_ac=7'h25; o_rw/o_bus_req low the clock after o_valid.
- Data read, i_rs=1, i_db=8'h3C:
  - Required: o_rs=1 throughout; o_data=3C, o_bf=0, o_ac keeps its previous 25.
- i_db changes from 8'h00 to 8'hFF one clock before E falls:
  - Required: o_data=FF, proving capture happens on the E-falling edge.
- i_start held high continuously:
  - Required: back-to-back reads, o_busy low for exactly one clock between them; a second i_start pulse during an operation is ignored.
- i_reset_n driven low while in E_HIGH:
  - Required: o_e, o_rw, o_busy and o_bus_req drop without waiting for a clock edge; no o_valid; after release, a new i_start completes normally.
- With HD44780_READ_4BIT_EN defined, i_db[7:4]=4'h8 on the first pulse and 4'h1 on the second:
  - Required: two E pulses; o_data=81, o_bf=1, o_ac=01.

Source files
------------

// File: rtl/hd44780_read_operation.sv
// HD44780 bus-read engine: drives RS/RW/E through one read cycle and samples DB7..DB0 as E falls.
// Define HD44780_READ_4BIT_EN for the 4-bit bus build (two E pulses, high nibble of i_db each time).
module hd44780_read_operation #(
  parameter int T_AS = 1,
  parameter int T_EH = 2,
  parameter int T_EL = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ena,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_db,
  output logic       o_rs,
  output logic       o_rw,
  output logic       o_e,
  output logic       o_bus_req,
  output logic       o_busy,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_bf,
  output logic [6:0] o_ac
);

  localparam int MAX_T = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                       : ((T_EH > T_EL) ? T_EH : T_EL);
  localparam int CW = $clog2(MAX_T) + 1;
  localparam logic [CW-1:0] LD_AS = CW'(T_AS);
  localparam logic [CW-1:0] LD_EH = CW'(T_EH);
  localparam logic [CW-1:0] LD_EL = CW'(T_EL);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, E_LOW, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [7:0]      shift, shift_nx;
  logic            active, active_nx;
  logic            rs_nx, rw_nx, e_nx, valid_nx, bf_nx;
  logic [7:0]      data_nx;
  logic [6:0]      ac_nx;
  logic            expire;

`ifdef HD44780_READ_4BIT_EN
  logic nibble, nibble_nx;
  logic unused_db_low;
  assign unused_db_low = ^i_db[3:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) nibble <= 1'b0;
    else            nibble <= nibble_nx;
  end
`endif

  // A phase ends on the tick that takes the counter from 1 to 0.
  assign expire    = i_ena && (cnt == ONE);
  assign o_busy    = active;
  assign o_bus_req = active;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      active  <= 1'b0;
      o_rs    <= 1'b0;
      o_rw    <= 1'b0;
      o_e     <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_bf    <= 1'b0;
      o_ac    <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      shift   <= shift_nx;
      active  <= active_nx;
      o_rs    <= rs_nx;
      o_rw    <= rw_nx;
      o_e     <= e_nx;
      o_valid <= valid_nx;
      o_data  <= data_nx;
      o_bf    <= bf_nx;
      o_ac    <= ac_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shift_nx  = shift;
    active_nx = active;
    rs_nx     = o_rs;
    rw_nx     = o_rw;
    e_nx      = o_e;
    valid_nx  = 1'b0;
    data_nx   = o_data;
    bf_nx     = o_bf;
    ac_nx     = o_ac;
`ifdef HD44780_READ_4BIT_EN
    nibble_nx = nibble;
`endif
    case (state)
      IDLE: begin
        if (i_start) begin
          rs_nx     = i_rs;
          rw_nx     = 1'b1;
          active_nx = 1'b1;
          cnt_nx    = LD_AS;
          state_nx  = SETUP;
`ifdef HD44780_READ_4BIT_EN
          nibble_nx = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (expire) begin
          e_nx     = 1'b1;
          cnt_nx   = LD_EH;
          state_nx = E_HIGH;
        end else if (i_ena) begin
          cnt_nx = cnt - ONE;
        end
      end
      E_HIGH: begin
        // Sample on the same edge that drops E, giving the LCD the full high time to drive DB.
        if (expire) begin
          e_nx     = 1'b0;
          cnt_nx   = LD_EL;
          state_nx = E_LOW;
`ifdef HD44780_READ_4BIT_EN
          if (!nibble) shift_nx[7:4] = i_db[7:4];
          else         shift_nx[3:0] = i_db[7:4];
`else
          shift_nx = i_db;
`endif
        end else if (i_ena) begin
          cnt_nx = cnt - ONE;
        end
      end
      E_LOW: begin
        if (expire) begin
`ifdef HD44780_READ_4BIT_EN
          if (!nibble) begin
            nibble_nx = 1'b1;
            e_nx      = 1'b1;
            cnt_nx    = LD_EH;
            state_nx  = E_HIGH;
          end else begin
            state_nx = DONE;
          end
`else
          state_nx = DONE;
`endif
        end else if (i_ena) begin
          cnt_nx = cnt - ONE;
        end
      end
      DONE: begin
        valid_nx  = 1'b1;
        data_nx   = shift;
        rw_nx     = 1'b0;
        active_nx = 1'b0;
        state_nx  = IDLE;
        // An RS=1 read returns RAM data, so the last known address counter is kept.
        if (!o_rs) begin
          bf_nx = shift[7];
          ac_nx = shift[6:0];
        end else begin
          bf_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hd44780_read_operation.sv
// Scoreboard bench for hd44780_read_operation: stimulus pushes expected reads, a monitor pops them on o_valid.
// Also follows HD44780_READ_4BIT_EN so the same bench covers the 4-bit build.
module tb_hd44780_read_operation;

  localparam int T_AS = 1;
  localparam int T_EH = 2;
  localparam int T_EL = 2;
`ifdef HD44780_READ_4BIT_EN
  localparam int PULSES = 2;
`else
  localparam int PULSES = 1;
`endif
  localparam int TOTAL_TICKS = T_AS + PULSES * (T_EH + T_EL);

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] db = 8'h00;
  logic       rs_pin, rw_pin, e_pin, bus_req, busy, valid, bf;
  logic [7:0] data;
  logic [6:0] ac;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       bf;
    logic [6:0] ac;
  } exp_t;

  exp_t       sb[$];
  exp_t       got;
  logic [6:0] model_ac = 7'h00;
  int         checks = 0;
  int         fails = 0;
  int         period = 5;
  int         div = 0;
  bit         hold_mode = 1'b0;

  hd44780_read_operation #(.T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_ena(ena), .i_start(start), .i_rs(rs), .i_db(db),
    .o_rs(rs_pin), .o_rw(rw_pin), .o_e(e_pin), .o_bus_req(bus_req), .o_busy(busy),
    .o_valid(valid), .o_data(data), .o_bf(bf), .o_ac(ac)
  );

  always #5 clk = ~clk;

  // Tick strobe: one clock in every 'period', changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    div = (div >= period - 1) ? 0 : div + 1;
    ena = (div == 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference: the byte the LCD presents, and what BF/AC mean for that register select.
  function automatic exp_t model(input logic r, input logic [7:0] first, input logic [7:0] second);
    exp_t       e;
    logic [7:0] byte_read;
`ifdef HD44780_READ_4BIT_EN
    byte_read = {first[7:4], second[7:4]};
`else
    byte_read = first;
    if (second === 8'hxx) byte_read = first;
`endif
    e.rs   = r;
    e.data = byte_read;
    if (!r) begin
      e.bf     = byte_read[7];
      e.ac     = byte_read[6:0];
      model_ac = byte_read[6:0];
    end else begin
      e.bf = 1'b0;
      e.ac = model_ac;
    end
    return e;
  endfunction

  int  e_run = 0, pulses = 0, lat_ticks = 0, low_run = 0;
  bit  e_prev = 1'b0, ena_d1 = 1'b0, ena_d2 = 1'b0, busy_prev = 1'b0, gap_armed = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      e_prev = 1'b0; e_run = 0; pulses = 0; busy_prev = 1'b0; low_run = 0; gap_armed = 1'b0;
      if (valid) checkOutput("valid_in_reset", 32'(valid), 32'd0);
    end else begin
      if (valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          checkOutput("data", 32'(data), 32'(got.data));
          checkOutput("bf", 32'(bf), 32'(got.bf));
          checkOutput("ac", 32'(ac), 32'(got.ac));
          checkOutput("latency_ticks", 32'(lat_ticks - int'(ena_d1)), 32'(TOTAL_TICKS));
          checkOutput("last_tick_then_one_clock", 32'(ena_d2), 32'd1);
          checkOutput("e_pulses", 32'(pulses), 32'(PULSES));
          checkOutput("released_at_valid", 32'({rw_pin, bus_req, busy}), 32'd0);
        end
        pulses = 0;
      end
      if (e_pin) begin
        checkOutput("e_implies_read", 32'({rw_pin, bus_req}), 32'd3);
        if (sb.size() > 0) checkOutput("rs_during_e", 32'(rs_pin), 32'(sb[0].rs));
        e_run++;
      end else if (e_prev) begin
        checkOutput("e_width", 32'(e_run), 32'(T_EH * period));
        pulses++;
        e_run = 0;
      end
      e_prev = e_pin;
      if (busy) begin
        if (!busy_prev && gap_armed && hold_mode) checkOutput("idle_gap", 32'(low_run), 32'd1);
        low_run = 0;
        gap_armed = hold_mode;
      end else begin
        low_run++;
      end
      busy_prev = busy;
      ena_d2 = ena_d1;
      ena_d1 = ena;
      if (start && !busy) lat_ticks = 0;
      else                lat_ticks += int'(ena);
    end
  end

  task automatic wait_busy(input logic level, input string name);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (busy == level) return;
    end
    checkOutput(name, 32'd1, 32'd0);
  endtask

  task automatic issue(input logic r, input logic [7:0] bus, input exp_t e);
    @(posedge clk); #1;
    rs = r; db = bus; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] first, input logic [7:0] second);
    wait_busy(1'b0, "idle_timeout");
    issue(r, first, model(r, first, second));
`ifdef HD44780_READ_4BIT_EN
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 2000; n++) begin
        @(negedge clk);
        if (e_pin) seen = 1'b1;
        else if (seen) break;
      end
      db = second;
    end
`endif
    wait_busy(1'b0, "done_timeout");
  endtask

  task automatic check_reset_state(input string name);
    checkOutput({name, "_ctrl"}, 32'({rs_pin, rw_pin, e_pin, bus_req, busy, valid, bf}), 32'd0);
    checkOutput({name, "_data"}, 32'(data), 32'd0);
    checkOutput({name, "_ac"}, 32'(ac), 32'd0);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       r[4];
    logic [7:0] d[4];
    int         ticks;
    bit         switched;

    #2 reset_n = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // Busy-flag read then data read; AC must survive the RS=1 read.
    period = 5;
    applyStimulus(1'b0, 8'hA5, 8'h5A);
    applyStimulus(1'b1, 8'h3C, 8'hC3);
    applyStimulus(1'b0, 8'h81, 8'h1F);

    // Bus switches 00 -> FF one clock before E falls; only a falling-edge capture sees FF.
    wait_busy(1'b0, "idle_timeout");
    issue(1'b0, 8'h00, model(1'b0, 8'hFF, 8'hFF));
    for (int n = 0; n < 200 && !e_pin; n++) @(negedge clk);
    ticks = 0;
    switched = 1'b0;
    for (int n = 0; n < 200 && !switched; n++) begin
      if (ticks + int'(ena) == T_EH - 1 && div == period - 1) begin
        @(posedge clk); #1 db = 8'hFF;
        switched = 1'b1;
      end else begin
        ticks += int'(ena);
        @(negedge clk);
      end
    end
    checkOutput("db_switch_scheduled", 32'(switched), 32'd1);
    wait_busy(1'b0, "done_timeout");

    // Start held high: three back-to-back reads; mid-operation RS changes are ignored.
    for (int i = 0; i < 4; i++) begin
      r[i] = 1'($urandom_range(0, 1));
      d[i] = 8'($urandom);
    end
    wait_busy(1'b0, "idle_timeout");
    hold_mode = 1'b1;
    @(posedge clk); #1;
    rs = r[0]; db = d[0];
    sb.push_back(model(r[0], d[0], d[0]));
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_busy(1'b1, "held_accept_timeout");
      rs = ~rs;
      wait_busy(1'b0, "held_done_timeout");
      if (i < 3) begin
        rs = r[i]; db = d[i];
        sb.push_back(model(r[i], d[i], d[i]));
      end else begin
        start = 1'b0;
        hold_mode = 1'b0;
      end
    end

    // A second start pulse while busy must not create another read.
    wait_busy(1'b0, "idle_timeout");
    issue(1'b1, 8'h6E, model(1'b1, 8'h6E, 8'h6E));
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_busy(1'b0, "done_timeout");
    repeat (TOTAL_TICKS * period + 10) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    // Reset while E is high: pins drop with no clock edge and no o_valid follows.
    issue(1'b0, 8'h47, model(1'b0, 8'h47, 8'h47));
    for (int n = 0; n < 200 && !e_pin; n++) @(negedge clk);
    checkOutput("reached_e_high", 32'(e_pin), 32'd1);
    #1 reset_n = 1'b0;
    #1 checkOutput("async_reset_pins", 32'({e_pin, rw_pin, busy, bus_req}), 32'd0);
    sb.delete();
    model_ac = 7'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_reset_state("mid_op_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    applyStimulus(1'b1, 8'h99, 8'h99);
    applyStimulus(1'b0, 8'hD2, 8'h2D);

    // Random reads with varying tick spacing.
    for (int i = 0; i < 12; i++) begin
      wait_busy(1'b0, "idle_timeout");
      period = $urandom_range(2, 6);
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    repeat (20) @(negedge clk);
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
